lcd_char_capture: RTL and testbench
===================================

// Module: lcd_char_capture
// PURPOSE
//  HD44780-style responder for the 2x16 character LCD bus (lcd_rs/lcd_rw/lcd_e/lcd_data) driven by lcd_driver.
//  Decodes commands, holds a 32-char DDRAM image, models the busy flag and answers bus reads.
//  Used as the on-chip/bench display model: checks the clock/date screen without a physical panel.
// PARAMETERS
//  BUSY_CYCLES   2000   clk cycles busy after any accepted access except clear (>=1)
//  CLEAR_CYCLES  82000  clk cycles busy after clear display (>=32; DDRAM fill uses the first 32)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  reset; synchronous, active-low
//  lcd_rs        in   1  register select: 0 = instruction/status, 1 = data
//  lcd_rw        in   1  0 = write, 1 = read
//  lcd_e         in   1  enable strobe; access committed on its falling edge
//  lcd_data      in   8  write data from the initiator
//  rd_data       out  8  read response: {busy, addr[6:0]} or DDRAM byte; held until the next read
//  rd_valid      out  1  1-cycle pulse when rd_data updates
//  busy          out  1  busy flag
//  display_on    out  1  display-control D bit
//  cursor_addr   out  5  DDRAM index 0..31 (0-15 = line 1 @0x00, 16-31 = line 2 @0x40)
//  wr_strobe     out  1  1-cycle pulse for each DDRAM data write
//  viol          out  1  1-cycle pulse: bad access (see BEHAVIOUR)
//  dbg_index     in   5  DDRAM debug read index
//  dbg_char      out  8  ddram[dbg_index], registered, 1-cycle latency
// BEHAVIOUR
//  Reset (rst==0 @ posedge): all 32 DDRAM bytes=0x20, cursor_addr=0, entry inc=1, display_on=0,
//   busy=0, rd_data=0, rd_valid=0, wr_strobe=0, viol=0, dbg_char=0, busy counter=0, fill FSM=IDLE.
//   A reset mid-access or mid-clear aborts it and DDRAM is re-filled with 0x20.
//  Edge detect: e_q <= lcd_e each clk. While lcd_e==1, rs/rw/data are latched every cycle.
//   Falling edge (e_q==1 && lcd_e==0) commits the latched access; commit happens in that cycle.
//  Write instruction (rs=0,rw=0), decoded on the highest set bit:
//   0x01 clear: FSM IDLE->FILL, writes 0x20 to idx 0..31 (1/cycle) ->IDLE; addr=0, inc=1; busy=CLEAR_CYCLES
//   0x02-0x03 return home: addr=0, DDRAM unchanged
//   0x04-0x07 entry mode: inc=data[1]; shift bit data[0] ignored
//   0x08-0x0F display ctrl: display_on=data[2]; cursor/blink bits ignored
//   0x10-0x1F cursor/shift: when data[3]=0, addr +1 if data[2] else -1 (wrap); display shift ignored
//   0x20-0x3F function set: no effect. 0x40-0x7F CGRAM addr: sets cg_mode (data writes discarded
//    until next DDRAM addr set)
//   0x80-0xFF DDRAM addr A=data[6:0]: 0x00-0x0F->idx A, 0x40-0x4F->idx 16+A[3:0], clears cg_mode;
//    other A -> viol pulse, addr unchanged
//  Write data (rs=1,rw=0): if !cg_mode, ddram[addr]=data and wr_strobe pulse. Then addr += inc?+1:-1.
//   31->0 and 0->31 wrap; 15->16 is linear.
//  Read status (rs=0,rw=1): rd_data={busy, line?(0x40|addr[3:0]):addr[3:0]}, rd_valid; always serviced.
//  Read data (rs=1,rw=1): rd_data=ddram[addr], rd_valid, then addr steps as for data write.
//  Busy: every accepted access except status read loads the counter (BUSY_CYCLES, or CLEAR_CYCLES for
//   clear); busy=1 while counter!=0; decrement 1/cycle; busy goes 0 exactly N cycles after commit.
//  Access during busy (other than status read): see CONFIGURATION.
//  Simultaneous: a commit on the same cycle the counter reaches 0 is treated as not-busy.
//   A commit during FILL is always dropped with a viol pulse (both configs).
//  dbg_char: ddram read bypasses the busy check; reflects writes committed in earlier cycles.
// CONFIGURATION
//  LCD_CAPTURE_STRICT_EN defined: accesses committed while busy=1 are dropped (no state change,
//   no counter reload) and pulse viol.
//  Not defined: such accesses are executed normally and reload the counter; viol is not pulsed for
//   busy. Bad DDRAM addr and commit-during-FILL still pulse viol.
// TESTING
//  reset, no bus activity -> every dbg_char==0x20, cursor_addr=0, busy=0, display_on=0
//  write 0x0C then data 'A'(0x41) -> display_on=1, ddram[0]=0x41, wr_strobe x1, cursor_addr=1
//  write 0xC5 then data 0x31 -> ddram[21]=0x31; write 0x8F, two data writes -> idx 15 then 16
//  write 0x04 (dec), addr 0, data 0x5A -> ddram[0]=0x5A, cursor_addr=31
//  clear -> all 0x20 after 32 cycles, busy high exactly CLEAR_CYCLES; status read mid-clear ->
//   rd_data[7]=1, rd_valid pulse
//  STRICT: data write inside BUSY_CYCLES -> viol, DDRAM unchanged; non-STRICT: write lands; bad
//   address 0x20 -> viol, cursor_addr unchanged

Source files
------------

// File: rtl/lcd_char_capture.sv
// HD44780-style 2x16 LCD bus responder: command decode, DDRAM image, busy flag, reads.
// Define LCD_CAPTURE_STRICT_EN to drop (and flag) non-status accesses made while busy.
module lcd_char_capture #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       display_on,
  output logic [4:0] cursor_addr,
  output logic       wr_strobe,
  output logic       viol,
  input  logic [4:0] dbg_index,
  output logic [7:0] dbg_char
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);

`ifdef LCD_CAPTURE_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state_q, state_d;
  logic [7:0]    ddram [32];
  logic [CW-1:0] cnt;
  logic [4:0]    fill_idx;
  logic          e_q, rs_q, rw_q, inc, cg_mode;
  logic [7:0]    d_q;
  logic          commit, stat_rd, blocked, exec, do_clear;
  logic [4:0]    step;
  logic [6:0]    ac;

  assign busy     = (cnt != '0);
  assign commit   = e_q & ~lcd_e;
  assign stat_rd  = ~rs_q & rw_q;
  assign blocked  = (state_q == FILL) | (STRICT & busy);
  assign exec     = commit & ~stat_rd & ~blocked;
  assign do_clear = exec & ~rs_q & ~rw_q & (d_q == 8'h01);
  assign step     = inc ? cursor_addr + 5'd1 : cursor_addr - 5'd1;
  assign ac       = cursor_addr[4] ? {3'b100, cursor_addr[3:0]}
                                   : {3'b000, cursor_addr[3:0]};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (do_clear) state_d = FILL;
      FILL: if (fill_idx == 5'd31) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      cnt         <= '0;
      fill_idx    <= '0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      d_q         <= '0;
      inc         <= 1'b1;
      cg_mode     <= 1'b0;
      cursor_addr <= '0;
      display_on  <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      wr_strobe   <= 1'b0;
      viol        <= 1'b0;
      dbg_char    <= '0;
    end else begin
      e_q       <= lcd_e;
      rd_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      viol      <= 1'b0;
      dbg_char  <= ddram[dbg_index];
      if (lcd_e) begin
        rs_q <= lcd_rs;
        rw_q <= lcd_rw;
        d_q  <= lcd_data;
      end
      if (busy) cnt <= cnt - 1'b1;
      if (state_q == FILL) begin
        ddram[fill_idx] <= 8'h20;
        fill_idx        <= fill_idx + 5'd1;
      end
      if (commit && stat_rd) begin
        rd_data  <= {busy, ac};
        rd_valid <= 1'b1;
      end else if (commit && blocked) begin
        viol <= 1'b1;
      end else if (exec) begin
        cnt <= CW'(BUSY_CYCLES);
        if (rs_q) begin
          if (rw_q) begin
            rd_data  <= ddram[cursor_addr];
            rd_valid <= 1'b1;
          end else if (!cg_mode) begin
            ddram[cursor_addr] <= d_q;
            wr_strobe          <= 1'b1;
          end
          cursor_addr <= step;
        end else begin
          // Decode on the highest set bit of the instruction byte.
          unique case (1'b1)
            d_q[7]: begin
              if (d_q[6:4] == 3'b000) begin
                cursor_addr <= {1'b0, d_q[3:0]};
                cg_mode     <= 1'b0;
              end else if (d_q[6:4] == 3'b100) begin
                cursor_addr <= {1'b1, d_q[3:0]};
                cg_mode     <= 1'b0;
              end else begin
                viol <= 1'b1;
              end
            end
            d_q[7:6] == 2'b01: cg_mode <= 1'b1;
            d_q[7:5] == 3'b001: ;
            d_q[7:4] == 4'b0001:
              if (!d_q[3])
                cursor_addr <= d_q[2] ? cursor_addr + 5'd1
                                      : cursor_addr - 5'd1;
            d_q[7:3] == 5'b00001: display_on <= d_q[2];
            d_q[7:2] == 6'b000001: inc <= d_q[1];
            d_q[7:1] == 7'b0000001: cursor_addr <= '0;
            d_q == 8'h01: begin
              cursor_addr <= '0;
              inc         <= 1'b1;
              fill_idx    <= '0;
              cnt         <= CW'(CLEAR_CYCLES);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_char_capture.sv
// Directed bench for lcd_char_capture with short busy/clear timings.
module tb_lcd_char_capture;

  localparam int BC = 20;
  localparam int CC = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [7:0] lcd_data = '0;
  logic [4:0] dbg_index = '0;
  logic [7:0] rd_data, dbg_char;
  logic       rd_valid, busy, display_on, wr_strobe, viol;
  logic [4:0] cursor_addr;

  int checks = 0;
  int errors = 0;
  logic       s_viol, s_wr, s_rv;
  logic [7:0] s_rd;

  lcd_char_capture #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .display_on(display_on),
    .cursor_addr(cursor_addr), .wr_strobe(wr_strobe), .viol(viol),
    .dbg_index(dbg_index), .dbg_char(dbg_char)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic acc(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    @(negedge clk);
    @(negedge clk);
    lcd_e = 1'b0;
    @(negedge clk);
    s_viol = viol; s_wr = wr_strobe; s_rv = rd_valid; s_rd = rd_data;
  endtask

  task automatic idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic cmd(input logic [7:0] d);
    idle();
    acc(1'b0, 1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    idle();
    acc(1'b1, 1'b0, d);
  endtask

  task automatic dbg(input string tag, input logic [4:0] i,
                     input logic [7:0] exp);
    @(negedge clk);
    dbg_index = i;
    @(negedge clk);
    chk(tag, 32'(dbg_char), 32'(exp));
  endtask

  task automatic busy_len(input string tag, input int exp);
    int n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cursor", 32'(cursor_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_disp", 32'(display_on), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_dbg", 32'(dbg_char), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) dbg("rst_ddram", 5'(i), 8'h20);

    cmd(8'h0C);
    chk("disp_on", 32'(display_on), 32'd1);
    dat(8'h41);
    chk("wr_strobe_A", 32'(s_wr), 32'd1);
    chk("cur_after_A", 32'(cursor_addr), 32'd1);
    dbg("ddram0_A", 5'd0, 8'h41);

    cmd(8'hC5);
    chk("cur_C5", 32'(cursor_addr), 32'd21);
    dat(8'h31);
    dbg("ddram21", 5'd21, 8'h31);
    chk("cur_22", 32'(cursor_addr), 32'd22);

    cmd(8'h8F);
    dat(8'h61);
    dat(8'h62);
    dbg("ddram15", 5'd15, 8'h61);
    dbg("ddram16", 5'd16, 8'h62);
    chk("cur_17", 32'(cursor_addr), 32'd17);

    cmd(8'h04);
    cmd(8'h80);
    dat(8'h5A);
    dbg("ddram0_dec", 5'd0, 8'h5A);
    chk("cur_wrap31", 32'(cursor_addr), 32'd31);

    idle();
    acc(1'b0, 1'b1, 8'h00);
    chk("stat_rv", 32'(s_rv), 32'd1);
    chk("stat_rd", 32'(s_rd), 32'h4F);
    chk("stat_nobusy", 32'(busy), 32'd0);

    cmd(8'h80);
    idle();
    acc(1'b1, 1'b1, 8'h00);
    chk("rdd_rv", 32'(s_rv), 32'd1);
    chk("rdd_data", 32'(s_rd), 32'h5A);
    chk("rdd_cur", 32'(cursor_addr), 32'd31);

    cmd(8'h14);
    chk("shift_r", 32'(cursor_addr), 32'd0);
    cmd(8'h10);
    chk("shift_l", 32'(cursor_addr), 32'd31);

    cmd(8'hA0);
    chk("bad_viol", 32'(s_viol), 32'd1);
    chk("bad_cur", 32'(cursor_addr), 32'd31);

    cmd(8'h06);
    cmd(8'h40);
    dat(8'h77);
    chk("cg_nowr", 32'(s_wr), 32'd0);
    chk("cg_cur", 32'(cursor_addr), 32'd0);
    dbg("cg_ddram31", 5'd31, 8'h20);
    cmd(8'h80);

    cmd(8'h02);
    chk("home_cur", 32'(cursor_addr), 32'd0);
    busy_len("busy_len", BC);

    dat(8'h11);
    acc(1'b1, 1'b0, 8'h22);
`ifdef LCD_CAPTURE_STRICT_EN
    chk("strict_viol", 32'(s_viol), 32'd1);
    chk("strict_cur", 32'(cursor_addr), 32'd1);
    dbg("strict_ddram1", 5'd1, 8'h20);
`else
    chk("busy_wr_viol", 32'(s_viol), 32'd0);
    chk("busy_wr_cur", 32'(cursor_addr), 32'd2);
    dbg("busy_wr_ddram1", 5'd1, 8'h22);
`endif
    dbg("ddram0_11", 5'd0, 8'h11);

    cmd(8'h01);
    busy_len("clear_len", CC);
    chk("clear_cur", 32'(cursor_addr), 32'd0);
    for (int i = 0; i < 32; i++) dbg("clear_ddram", 5'(i), 8'h20);

    cmd(8'h01);
    repeat (33) @(negedge clk);
    acc(1'b0, 1'b1, 8'h00);
    chk("clr_stat_rv", 32'(s_rv), 32'd1);
    chk("clr_stat_rd", 32'(s_rd), 32'h80);

    cmd(8'h01);
    acc(1'b1, 1'b0, 8'h55);
    chk("fill_viol", 32'(s_viol), 32'd1);
    idle();
    dbg("fill_ddram0", 5'd0, 8'h20);
    chk("fill_cur", 32'(cursor_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
